// File: rtl/move_list_reader.sv
// Walks the all_moves RAM from index 0 to move_count-1, waits out the read
// latency per entry, and streams each captured position out on valid/ready.
module move_list_reader #(
  parameter int unsigned PIECE_WIDTH        = 4,
  parameter int unsigned SIDE_WIDTH         = PIECE_WIDTH * 8,
  parameter int unsigned BOARD_WIDTH        = SIDE_WIDTH * 8,
  parameter int unsigned MAX_POSITIONS_LOG2 = 8,
  parameter int unsigned READ_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          white_to_move_in,
  input  logic [3:0]                    castle_mask_in,
  input  logic [3:0]                    en_passant_col_in,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BOARD_WIDTH-1:0]        board_out,
  output logic                          white_to_move_out,
  output logic [3:0]                    castle_mask_out,
  output logic [3:0]                    en_passant_col_out,
  output logic [MAX_POSITIONS_LOG2-1:0] out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned LOG2 = MAX_POSITIONS_LOG2;
  localparam int unsigned WCW  = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WAIT, PRESENT, CLEAR, DRAIN} state_t;

  state_t          state;
  logic [LOG2-1:0] count_q;
  logic [WCW-1:0]  wait_cnt;
  logic [LOG2:0]   next_idx;
  logic            more;

  // One extra bit so index+1 never wraps when compared against the count.
  always_comb begin
    next_idx = {1'b0, move_index} + 1'b1;
    more     = next_idx < {1'b0, count_q};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count_q            <= '0;
      wait_cnt           <= '0;
      move_index         <= '0;
      clear_moves        <= 1'b0;
      out_valid          <= 1'b0;
      board_out          <= '0;
      white_to_move_out  <= 1'b0;
      castle_mask_out    <= '0;
      en_passant_col_out <= 4'b1000;
      out_index          <= '0;
      out_last           <= 1'b0;
      done               <= 1'b0;
    end else begin
      clear_moves <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          move_index <= '0;
          if (moves_ready) begin
            if (move_count != '0) begin
              count_q  <= move_count;
              wait_cnt <= WCW'(READ_LATENCY);
              state    <= WAIT;
            end else begin
              clear_moves <= 1'b1;
              state       <= CLEAR;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            out_valid   <= 1'b0;
            clear_moves <= 1'b1;
            state       <= CLEAR;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            board_out          <= board_in;
            white_to_move_out  <= white_to_move_in;
            castle_mask_out    <= castle_mask_in;
            en_passant_col_out <= en_passant_col_in;
            out_index          <= move_index;
            out_last           <= (next_idx == {1'b0, count_q});
            out_valid          <= 1'b1;
            state              <= PRESENT;
          end
        end
        PRESENT: begin
          // Abort wins over advancing; a coincident transfer still completes.
          if (abort || out_ready) out_valid <= 1'b0;
          if (abort || (out_ready && !more)) begin
            clear_moves <= 1'b1;
            state       <= CLEAR;
          end else if (out_ready) begin
            move_index <= next_idx[LOG2-1:0];
            wait_cnt   <= WCW'(READ_LATENCY);
            state      <= WAIT;
          end
        end
        CLEAR: begin
          move_index <= '0;
          state      <= DRAIN;
        end
        DRAIN: begin
          if (!moves_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
